// File: rtl/itch_msg_decoder_if.sv
// Byte stream from the UDP/MoldUDP64 parser into the ITCH decoder, and the decoded
// message record out to the order-book stage.
interface itch_msg_decoder_if;
    logic        itchDataValidIn;
    logic [7:0]  itchDataIn;
    logic        packetLostIn;
    logic        msgValidOut;
    logic [1:0]  msgTypeOut;
    logic [15:0] locateOut;
    logic [47:0] timeStampOut;
    logic [63:0] refNumOut;
    logic        sideOut;
    logic [31:0] sharesOut;
    logic [63:0] stockOut;
    logic [31:0] priceOut;
    logic        errTypeOut;
    logic        errShortOut;
    logic        errLongOut;
    logic        gapOut;

    modport master (
        output itchDataValidIn, itchDataIn, packetLostIn,
        input  msgValidOut, msgTypeOut, locateOut, timeStampOut, refNumOut, sideOut,
               sharesOut, stockOut, priceOut, errTypeOut, errShortOut, errLongOut, gapOut
    );

    modport slave (
        input  itchDataValidIn, itchDataIn, packetLostIn,
        output msgValidOut, msgTypeOut, locateOut, timeStampOut, refNumOut, sideOut,
               sharesOut, stockOut, priceOut, errTypeOut, errShortOut, errLongOut, gapOut
    );
endinterface

// File: rtl/itch_msg_decoder.sv
// Decodes one ITCH A/D/E/X message per parser burst into a field-aligned record,
// flagging unsupported types, short bursts and over-length bursts.
module itch_msg_decoder (
    input  logic               clkIn,
    input  logic               rstBIn,
    itch_msg_decoder_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, FIELDS, DISCARD} state_t;

    localparam logic [5:0] LEN_ADD = 6'd36;
    localparam logic [5:0] LEN_DEL = 6'd19;
    localparam logic [5:0] LEN_EXE = 6'd31;
    localparam logic [5:0] LEN_CAN = 6'd23;
    localparam logic [1:0] TYPE_ADD = 2'd0;
    localparam logic [1:0] TYPE_DEL = 2'd1;
    localparam logic [1:0] TYPE_EXE = 2'd2;
    localparam logic [1:0] TYPE_CAN = 2'd3;

    state_t      state, state_nxt;
    logic [5:0]  byte_cnt, exp_len, len_dec;
    logic [1:0]  type_sh, type_dec;
    logic        type_ok, long_armed, last_byte;
    logic        start_msg, load_record, err_type_nx, err_short_nx, err_long_nx;
    logic [15:0] locate_sh, locate_nx;
    logic [47:0] ts_sh, ts_nx;
    logic [63:0] ref_sh, ref_nx, stock_sh, stock_nx;
    logic        side_sh, side_nx;
    logic [31:0] shares_sh, shares_nx, price_sh, price_nx;

    wire       valid = bus.itchDataValidIn;
    wire [7:0] data  = bus.itchDataIn;

    always_comb begin
        type_ok  = 1'b1;
        type_dec = TYPE_ADD;
        len_dec  = LEN_ADD;
        case (data)
            8'h41:   begin type_dec = TYPE_ADD; len_dec = LEN_ADD; end
            8'h44:   begin type_dec = TYPE_DEL; len_dec = LEN_DEL; end
            8'h45:   begin type_dec = TYPE_EXE; len_dec = LEN_EXE; end
            8'h58:   begin type_dec = TYPE_CAN; len_dec = LEN_CAN; end
            default: type_ok = 1'b0;
        endcase
    end

    assign last_byte = (byte_cnt == exp_len - 6'd1);

    always_ff @(posedge clkIn or negedge rstBIn) begin
        if (!rstBIn) state <= IDLE;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (valid) state_nxt = type_ok ? FIELDS : DISCARD;
            FIELDS:  if (!valid) state_nxt = IDLE;
                     else if (last_byte) state_nxt = DISCARD;
            DISCARD: if (!valid) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        start_msg    = 1'b0;
        load_record  = 1'b0;
        err_type_nx  = 1'b0;
        err_short_nx = 1'b0;
        err_long_nx  = 1'b0;
        case (state)
            IDLE:    if (valid) begin
                         start_msg   = type_ok;
                         err_type_nx = !type_ok;
                     end
            FIELDS:  if (!valid) err_short_nx = 1'b1;
                     else if (last_byte) load_record = 1'b1;
            DISCARD: err_long_nx = valid && long_armed;
            default: ;
        endcase
    end

    // Multi-byte fields arrive big-endian, so each one is built by shifting bytes in from the right.
    always_comb begin
        locate_nx = locate_sh;
        ts_nx     = ts_sh;
        ref_nx    = ref_sh;
        side_nx   = side_sh;
        shares_nx = shares_sh;
        stock_nx  = stock_sh;
        price_nx  = price_sh;
        if (state == FIELDS && valid) begin
            if (byte_cnt inside {[6'd1:6'd2]})   locate_nx = {locate_sh[7:0], data};
            if (byte_cnt inside {[6'd5:6'd10]})  ts_nx     = {ts_sh[39:0], data};
            if (byte_cnt inside {[6'd11:6'd18]}) ref_nx    = {ref_sh[55:0], data};
            case (type_sh)
                TYPE_ADD: begin
                    if (byte_cnt == 6'd19)               side_nx   = (data == 8'h53);
                    if (byte_cnt inside {[6'd20:6'd23]}) shares_nx = {shares_sh[23:0], data};
                    if (byte_cnt inside {[6'd24:6'd31]}) stock_nx  = {stock_sh[55:0], data};
                    if (byte_cnt inside {[6'd32:6'd35]}) price_nx  = {price_sh[23:0], data};
                end
                TYPE_EXE, TYPE_CAN:
                    if (byte_cnt inside {[6'd19:6'd22]}) shares_nx = {shares_sh[23:0], data};
                default: ;
            endcase
        end
    end

    // errLongOut fires only for bursts that already produced a record, never for a rejected type.
    always_ff @(posedge clkIn or negedge rstBIn) begin
        if (!rstBIn) begin
            byte_cnt   <= '0;
            exp_len    <= '0;
            type_sh    <= '0;
            long_armed <= 1'b0;
            locate_sh  <= '0;
            ts_sh      <= '0;
            ref_sh     <= '0;
            side_sh    <= 1'b0;
            shares_sh  <= '0;
            stock_sh   <= '0;
            price_sh   <= '0;
        end else begin
            if (load_record)                          long_armed <= 1'b1;
            else if (err_long_nx || state != DISCARD) long_armed <= 1'b0;
            if (start_msg) begin
                byte_cnt  <= 6'd1;
                exp_len   <= len_dec;
                type_sh   <= type_dec;
                locate_sh <= '0;
                ts_sh     <= '0;
                ref_sh    <= '0;
                side_sh   <= 1'b0;
                shares_sh <= '0;
                stock_sh  <= '0;
                price_sh  <= '0;
            end else begin
                if (state == FIELDS && valid && byte_cnt != LEN_ADD) byte_cnt <= byte_cnt + 6'd1;
                locate_sh <= locate_nx;
                ts_sh     <= ts_nx;
                ref_sh    <= ref_nx;
                side_sh   <= side_nx;
                shares_sh <= shares_nx;
                stock_sh  <= stock_nx;
                price_sh  <= price_nx;
            end
        end
    end

    // gapOut stays high through the msgValidOut cycle so the record carries the gap tag.
    always_ff @(posedge clkIn or negedge rstBIn) begin
        if (!rstBIn) begin
            bus.msgValidOut  <= 1'b0;
            bus.msgTypeOut   <= '0;
            bus.locateOut    <= '0;
            bus.timeStampOut <= '0;
            bus.refNumOut    <= '0;
            bus.sideOut      <= 1'b0;
            bus.sharesOut    <= '0;
            bus.stockOut     <= '0;
            bus.priceOut     <= '0;
            bus.errTypeOut   <= 1'b0;
            bus.errShortOut  <= 1'b0;
            bus.errLongOut   <= 1'b0;
            bus.gapOut       <= 1'b0;
        end else begin
            bus.msgValidOut <= load_record;
            bus.errTypeOut  <= err_type_nx;
            bus.errShortOut <= err_short_nx;
            bus.errLongOut  <= err_long_nx;
            bus.gapOut      <= bus.packetLostIn || (bus.gapOut && !bus.msgValidOut);
            if (load_record) begin
                bus.msgTypeOut   <= type_sh;
                bus.locateOut    <= locate_nx;
                bus.timeStampOut <= ts_nx;
                bus.refNumOut    <= ref_nx;
                bus.sideOut      <= side_nx;
                bus.sharesOut    <= shares_nx;
                bus.stockOut     <= stock_nx;
                bus.priceOut     <= price_nx;
            end
        end
    end
endmodule

// File: tb/tb_itch_msg_decoder.sv
// Self-checking bench for itch_msg_decoder: directed scenarios plus randomized bursts,
// checked against a field-level message model.
module tb_itch_msg_decoder;
    typedef struct packed {
        logic [7:0]  kind;
        logic [15:0] locate;
        logic [15:0] track;
        logic [47:0] ts;
        logic [63:0] ref_num;
        logic [7:0]  side;
        logic [31:0] shares;
        logic [63:0] stock;
        logic [31:0] price;
        logic [63:0] match_num;
    } msg_t;

    typedef struct packed {
        logic [1:0]  msg_type;
        logic [15:0] locate;
        logic [47:0] ts;
        logic [63:0] ref_num;
        logic        side;
        logic [31:0] shares;
        logic [63:0] stock;
        logic [31:0] price;
    } rec_t;

    logic clk = 1'b0;
    logic rst_n;
    int   check_count = 0;
    int   fail_count = 0;

    logic [7:0] burst[$];
    msg_t cur_msg;
    rec_t held;
    bit   gap_exp;
    int   valid_count, valid_at, type_count, type_at, short_count, short_at, long_count, long_at;
    rec_t cap_rec;
    logic cap_gap;

    itch_msg_decoder_if bus ();

    itch_msg_decoder dut (
        .clkIn (clk),
        .rstBIn(rst_n),
        .bus   (bus)
    );

    always #2 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        check_count++;
        if (actual !== expected) begin
            fail_count++;
            $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", tag, actual, expected);
        end
    endtask

    function automatic int msg_length(input logic [7:0] kind);
        case (kind)
            8'h41:   return 36;
            8'h44:   return 19;
            8'h45:   return 31;
            8'h58:   return 23;
            default: return 0;
        endcase
    endfunction

    function automatic rec_t expected_record(input msg_t m);
        rec_t r;
        r = '0;
        r.locate  = m.locate;
        r.ts      = m.ts;
        r.ref_num = m.ref_num;
        case (m.kind)
            8'h41: begin
                r.msg_type = 2'd0;
                r.side     = (m.side == 8'h53);
                r.shares   = m.shares;
                r.stock    = m.stock;
                r.price    = m.price;
            end
            8'h44:   r.msg_type = 2'd1;
            8'h45:   begin r.msg_type = 2'd2; r.shares = m.shares; end
            default: begin r.msg_type = 2'd3; r.shares = m.shares; end
        endcase
        return r;
    endfunction

    function automatic rec_t read_record();
        rec_t r;
        r.msg_type = bus.msgTypeOut;
        r.locate   = bus.locateOut;
        r.ts       = bus.timeStampOut;
        r.ref_num  = bus.refNumOut;
        r.side     = bus.sideOut;
        r.shares   = bus.sharesOut;
        r.stock    = bus.stockOut;
        r.price    = bus.priceOut;
        return r;
    endfunction

    task automatic compare_record(input string prefix, input rec_t a, input rec_t e);
        checkOutput({prefix, "_type"},   64'(a.msg_type), 64'(e.msg_type));
        checkOutput({prefix, "_locate"}, 64'(a.locate),   64'(e.locate));
        checkOutput({prefix, "_ts"},     64'(a.ts),       64'(e.ts));
        checkOutput({prefix, "_ref"},    a.ref_num,       e.ref_num);
        checkOutput({prefix, "_side"},   64'(a.side),     64'(e.side));
        checkOutput({prefix, "_shares"}, 64'(a.shares),   64'(e.shares));
        checkOutput({prefix, "_stock"},  a.stock,         e.stock);
        checkOutput({prefix, "_price"},  64'(a.price),    64'(e.price));
    endtask

    task automatic check_all_zero(input string prefix);
        compare_record({prefix, "_rec"}, read_record(), '0);
        checkOutput({prefix, "_valid"},     64'(bus.msgValidOut), 64'd0);
        checkOutput({prefix, "_err_type"},  64'(bus.errTypeOut),  64'd0);
        checkOutput({prefix, "_err_short"}, 64'(bus.errShortOut), 64'd0);
        checkOutput({prefix, "_err_long"},  64'(bus.errLongOut),  64'd0);
        checkOutput({prefix, "_gap"},       64'(bus.gapOut),      64'd0);
    endtask

    task automatic push_be(input logic [63:0] value, input int nbytes);
        for (int i = nbytes - 1; i >= 0; i--) burst.push_back(value[i*8 +: 8]);
    endtask

    // Serialise a message the way the exchange lays it out on the wire.
    task automatic build_burst(input msg_t m);
        burst.delete();
        push_be(64'(m.kind), 1);
        push_be(64'(m.locate), 2);
        push_be(64'(m.track), 2);
        push_be(64'(m.ts), 6);
        push_be(m.ref_num, 8);
        case (m.kind)
            8'h41: begin
                push_be(64'(m.side), 1);
                push_be(64'(m.shares), 4);
                push_be(m.stock, 8);
                push_be(64'(m.price), 4);
            end
            8'h44: ;
            8'h45: begin push_be(64'(m.shares), 4); push_be(m.match_num, 8); end
            default: push_be(64'(m.shares), 4);
        endcase
    endtask

    task automatic random_message(input logic [7:0] kind, output msg_t m);
        m.kind      = kind;
        m.locate    = 16'($urandom);
        m.track     = 16'($urandom);
        m.ts        = {16'($urandom), 32'($urandom)};
        m.ref_num   = {$urandom, $urandom};
        case ($urandom_range(0, 2))
            0:       m.side = 8'h42;
            1:       m.side = 8'h53;
            default: m.side = 8'($urandom);
        endcase
        m.shares    = $urandom;
        m.stock     = {$urandom, $urandom};
        m.price     = $urandom;
        m.match_num = {$urandom, $urandom};
    endtask

    task automatic sample_outputs(input int k);
        if (bus.msgValidOut) begin
            valid_count++;
            valid_at = k;
            cap_rec  = read_record();
            cap_gap  = bus.gapOut;
        end
        if (bus.errTypeOut)  begin type_count++;  type_at = k;  end
        if (bus.errShortOut) begin short_count++; short_at = k; end
        if (bus.errLongOut)  begin long_count++;  long_at = k;  end
    endtask

    // Byte k is driven at negedge k; its consequences show up from negedge k+1 on.
    task automatic applyStimulus(input int idle_cycles);
        int n;
        n = burst.size();
        valid_count = 0; type_count = 0; short_count = 0; long_count = 0;
        valid_at = -1; type_at = -1; short_at = -1; long_at = -1;
        for (int k = 0; k <= n + idle_cycles; k++) begin
            @(negedge clk);
            sample_outputs(k);
            if (k < n) begin
                bus.itchDataValidIn = 1'b1;
                bus.itchDataIn      = burst[k];
            end else begin
                bus.itchDataValidIn = 1'b0;
                bus.itchDataIn      = 8'($urandom);
            end
        end
    endtask

    task automatic check_burst(input int n);
        int len;
        bit type_ok, full, is_short, is_long;
        len      = msg_length(cur_msg.kind);
        type_ok  = (len != 0);
        full     = type_ok && n >= len;
        is_short = type_ok && n < len;
        is_long  = type_ok && n > len;
        checkOutput("valid_count", 64'(valid_count), 64'(full));
        if (full) begin
            checkOutput("valid_latency", 64'(valid_at), 64'(len));
            compare_record("record", cap_rec, expected_record(cur_msg));
            checkOutput("gap_with_record", 64'(cap_gap), 64'(gap_exp));
            held    = expected_record(cur_msg);
            gap_exp = 1'b0;
        end
        checkOutput("err_type_count", 64'(type_count), 64'(!type_ok));
        if (!type_ok) checkOutput("err_type_latency", 64'(type_at), 64'd1);
        checkOutput("err_short_count", 64'(short_count), 64'(is_short));
        if (is_short) checkOutput("err_short_latency", 64'(short_at), 64'(n + 1));
        checkOutput("err_long_count", 64'(long_count), 64'(is_long));
        if (is_long) checkOutput("err_long_latency", 64'(long_at), 64'(len + 1));
        compare_record("held", read_record(), held);
        checkOutput("gap_after", 64'(bus.gapOut), 64'(gap_exp));
    endtask

    task automatic run_burst(input msg_t m, input int n, input int idle_cycles);
        cur_msg = m;
        build_burst(m);
        while (burst.size() > n) void'(burst.pop_back());
        while (burst.size() < n) burst.push_back(8'($urandom));
        applyStimulus(idle_cycles);
        check_burst(n);
    endtask

    task automatic pulse_lost();
        @(negedge clk);
        bus.packetLostIn = 1'b1;
        @(negedge clk);
        bus.packetLostIn = 1'b0;
        gap_exp = 1'b1;
        checkOutput("gap_set", 64'(bus.gapOut), 64'd1);
    endtask

    task automatic reset_mid_message();
        msg_t m;
        random_message(8'h41, m);
        build_burst(m);
        pulse_lost();
        for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            bus.itchDataValidIn = 1'b1;
            bus.itchDataIn      = burst[k];
        end
        @(negedge clk);
        rst_n = 1'b0;
        bus.itchDataValidIn = 1'b0;
        #1;
        check_all_zero("mid_reset");
        @(negedge clk);
        rst_n   = 1'b1;
        held    = '0;
        gap_exp = 1'b0;
    endtask

    initial begin
        msg_t       m;
        logic [7:0] kind;
        int         sel, len, n;

        rst_n = 1'b0;
        bus.itchDataValidIn = 1'b0;
        bus.itchDataIn      = 8'h00;
        bus.packetLostIn    = 1'b0;
        held    = '0;
        gap_exp = 1'b0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;

        m = '0;
        m.kind = 8'h41; m.locate = 16'hBE42; m.track = 16'h0001; m.ts = 48'h0;
        m.ref_num = 64'hDEFB1673DEFB1673; m.side = 8'h42; m.shares = 32'h45;
        m.stock = 64'h4141504C20202020; m.price = 32'h0022FEFC;
        run_burst(m, 36, 2);

        pulse_lost();
        m.ts = 48'h000000000123; m.ref_num = 64'h111B1673DEFB4321; m.side = 8'h53;
        m.shares = 32'h184; m.price = 32'h0021FEFC;
        run_burst(m, 36, 2);

        random_message(8'h44, m);
        run_burst(m, 19, 1);
        random_message(8'h45, m);
        m.shares = 32'h10;
        run_burst(m, 31, 1);
        random_message(8'h58, m);
        m.shares = 32'h5;
        run_burst(m, 23, 1);

        random_message(8'h41, m);
        run_burst(m, 20, 1);
        random_message(8'h46, m);
        run_burst(m, 12, 1);

        random_message(8'h41, m);
        run_burst(m, 39, 2);

        reset_mid_message();
        random_message(8'h41, m);
        run_burst(m, 36, 2);

        for (int it = 0; it < 40; it++) begin
            sel = $urandom_range(0, 4);
            case (sel)
                0: kind = 8'h41;
                1: kind = 8'h44;
                2: kind = 8'h45;
                3: kind = 8'h58;
                default: begin
                    kind = 8'($urandom);
                    while (msg_length(kind) != 0) kind = 8'($urandom);
                end
            endcase
            random_message(kind, m);
            len = msg_length(kind);
            sel = $urandom_range(0, 7);
            if (len == 0)      n = $urandom_range(1, 20);
            else if (sel == 6) n = $urandom_range(1, len - 1);
            else if (sel == 7) n = len + $urandom_range(1, 4);
            else               n = len;
            if ($urandom_range(0, 3) == 0) pulse_lost();
            run_burst(m, n, $urandom_range(1, 3));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", check_count, fail_count);
        $finish;
    end
endmodule
